// File: rtl/edge_sync_pkg.sv
// Shared definitions for the edge_sync_filter slice: per-channel edge-select
// encodings, legal parameter ranges and the edge-selection helper.
package edge_sync_pkg;

  localparam logic [1:0] MODE_NONE = 2'b00;
  localparam logic [1:0] MODE_RISE = 2'b01;
  localparam logic [1:0] MODE_FALL = 2'b10;
  localparam logic [1:0] MODE_BOTH = 2'b11;

  localparam int N_CH_MIN        = 1;
  localparam int N_CH_MAX        = 32;
  localparam int SYNC_STAGES_MIN = 2;
  localparam int SYNC_STAGES_MAX = 4;
  localparam int FILT_CYCLES_MIN = 1;
  localparam int FILT_CYCLES_MAX = 255;

  // True when a filtered transition to new_level is one the mode asks to report.
  function automatic logic edge_selected(input logic [1:0] mode, input logic new_level);
    logic sel;
    sel = 1'b0;
    case (mode)
      MODE_RISE: sel = new_level;
      MODE_FALL: sel = !new_level;
      MODE_BOTH: sel = 1'b1;
      default:   sel = 1'b0;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/edge_sync_ch.sv
// One channel of the edge filter: synchroniser chain, stability filter,
// registered edge pulse and sticky event flag.
module edge_sync_ch
  import edge_sync_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_CYCLES = 4,
  parameter bit RESET_LEVEL = 1'b1
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       async_i,
  input  logic [1:0] mode_i,
  input  logic       clear_i,
  output logic       level_o,
  output logic       pulse_o,
  output logic       event_o
);

  localparam int CNT_W = $clog2(FILT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILT_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CNT_W-1:0]       cnt_q;
  logic                   level_q;
  logic                   pulse_q;
  logic                   event_q;

  logic sample;
  logic differs;
  logic flip;
  logic pulse_d;

  assign sample  = sync_q[SYNC_STAGES-1];
  assign differs = (sample != level_q);
  assign flip    = differs && (cnt_q == CNT_LAST);
  assign pulse_d = flip && edge_selected(mode_i, sample);

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      sync_q <= {SYNC_STAGES{RESET_LEVEL}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
    end
  end

  // The count tracks consecutive clocks of disagreement; it saturates at the
  // flip point because the level change itself makes the sample agree again.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      cnt_q   <= '0;
      level_q <= RESET_LEVEL;
    end else if (!differs) begin
      cnt_q <= '0;
    end else if (flip) begin
      cnt_q   <= '0;
      level_q <= sample;
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // A set on the same edge as a clear wins, so no event is ever lost.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      pulse_q <= 1'b0;
      event_q <= 1'b0;
    end else begin
      pulse_q <= pulse_d;
      event_q <= pulse_d | (event_q & ~clear_i);
    end
  end

  assign level_o = level_q;
  assign pulse_o = pulse_q;
  assign event_o = event_q;

endmodule

// File: rtl/edge_sync_filter.sv
// Multi-channel synchronise/debounce/edge-detect front end for slow asynchronous
// inputs such as PS/2 clock and data; each channel is fully independent.
module edge_sync_filter
  import edge_sync_pkg::*;
#(
  parameter int N_CH        = 1,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_CYCLES = 4,
  parameter bit RESET_LEVEL = 1'b1
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic [N_CH-1:0]   async_i,
  input  logic [2*N_CH-1:0] mode_i,
  input  logic [N_CH-1:0]   clear_i,
  output logic [N_CH-1:0]   level_o,
  output logic [N_CH-1:0]   pulse_o,
  output logic [N_CH-1:0]   event_o
);

  if (N_CH < N_CH_MIN || N_CH > N_CH_MAX ||
      SYNC_STAGES < SYNC_STAGES_MIN || SYNC_STAGES > SYNC_STAGES_MAX ||
      FILT_CYCLES < FILT_CYCLES_MIN || FILT_CYCLES > FILT_CYCLES_MAX) begin : g_bad_cfg
    $error("edge_sync_filter: parameter out of supported range");
  end

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    edge_sync_ch #(
      .SYNC_STAGES (SYNC_STAGES),
      .FILT_CYCLES (FILT_CYCLES),
      .RESET_LEVEL (RESET_LEVEL)
    ) u_ch (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .async_i (async_i[c]),
      .mode_i  (mode_i[2*c+1:2*c]),
      .clear_i (clear_i[c]),
      .level_o (level_o[c]),
      .pulse_o (pulse_o[c]),
      .event_o (event_o[c])
    );
  end

endmodule

// File: tb/tb_edge_sync_filter.sv
// Self-checking bench: directed steps on a 2-channel FILT_CYCLES=4 instance and
// randomised traffic on a 4-channel FILT_CYCLES=1 instance, both scoreboarded.
module tb_edge_sync_filter;
  import edge_sync_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [1:0] async_a = 2'b11, clear_a = 2'b00;
  logic [3:0] mode_a  = 4'b0000;
  logic [1:0] level_a, pulse_a, event_a;

  logic [3:0] async_b = 4'hF, clear_b = 4'h0;
  logic [7:0] mode_b  = 8'h00;
  logic [3:0] level_b, pulse_b, event_b;

  edge_sync_filter #(.N_CH(2), .SYNC_STAGES(2), .FILT_CYCLES(4), .RESET_LEVEL(1'b1)) dut_a (
    .clk_i(clk), .reset_i(rst_n), .async_i(async_a), .mode_i(mode_a), .clear_i(clear_a),
    .level_o(level_a), .pulse_o(pulse_a), .event_o(event_a));

  edge_sync_filter #(.N_CH(4), .SYNC_STAGES(3), .FILT_CYCLES(1), .RESET_LEVEL(1'b1)) dut_b (
    .clk_i(clk), .reset_i(rst_n), .async_i(async_b), .mode_i(mode_b), .clear_i(clear_b),
    .level_o(level_b), .pulse_o(pulse_b), .event_o(event_b));

  typedef struct {
    logic [3:0] sync;
    logic [7:0] hist;
    logic       level;
    logic       pulse;
    logic       evt;
  } ch_model_t;

  typedef struct packed {
    logic [1:0] a_level, a_pulse, a_event;
    logic [3:0] b_level, b_pulse, b_event;
  } exp_t;

  ch_model_t ma[2];
  ch_model_t mb[4];
  exp_t      exp_q[$];
  int        n_asserts = 0;
  int        n_fail = 0;

  function automatic ch_model_t model_reset();
    ch_model_t m;
    m.sync = 4'hF; m.hist = 8'hFF; m.level = 1'b1; m.pulse = 1'b0; m.evt = 1'b0;
    return m;
  endfunction

  // Level flips once the last `filt` synchronised samples all oppose it.
  function automatic ch_model_t model_step(input ch_model_t m, input int stages, input int filt,
                                           input logic a, input logic [1:0] mode, input logic clr);
    ch_model_t  n;
    logic       s;
    logic [7:0] mask;
    logic [7:0] h;
    n    = m;
    s    = m.sync[stages-1];
    mask = 8'hFF >> (8 - filt);
    h    = {m.hist[6:0], s};
    n.hist  = h;
    n.pulse = 1'b0;
    if ((h & mask) == (m.level ? 8'h00 : mask)) begin
      n.level = ~m.level;
      n.pulse = (mode == 2'b11) || (mode == 2'b01 && n.level) || (mode == 2'b10 && !n.level);
    end
    n.evt  = n.pulse | (m.evt & ~clr);
    n.sync = {m.sync[2:0], a};
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < 2; c++) ma[c] = model_reset();
      for (int c = 0; c < 4; c++) mb[c] = model_reset();
      exp_q.delete();
    end else begin
      exp_t e;
      for (int c = 0; c < 2; c++) begin
        ma[c] = model_step(ma[c], 2, 4, async_a[c], mode_a[2*c +: 2], clear_a[c]);
        e.a_level[c] = ma[c].level; e.a_pulse[c] = ma[c].pulse; e.a_event[c] = ma[c].evt;
      end
      for (int c = 0; c < 4; c++) begin
        mb[c] = model_step(mb[c], 3, 1, async_b[c], mode_b[2*c +: 2], clear_b[c]);
        e.b_level[c] = mb[c].level; e.b_pulse[c] = mb[c].pulse; e.b_event[c] = mb[c].evt;
      end
      exp_q.push_back(e);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput();
    exp_t e;
    check("sb_nonempty", 32'(exp_q.size() > 0), 32'd1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("sb_a_level", level_a, e.a_level);
      check("sb_a_pulse", pulse_a, e.a_pulse);
      check("sb_a_event", event_a, e.a_event);
      check("sb_b_level", level_b, e.b_level);
      check("sb_b_pulse", pulse_b, e.b_pulse);
      check("sb_b_event", event_b, e.b_event);
    end
  endtask

  task automatic checkReset();
    check("rst_a_level", level_a, 2'b11);
    check("rst_a_pulse", pulse_a, 2'b00);
    check("rst_a_event", event_a, 2'b00);
    check("rst_b_level", level_b, 4'hF);
    check("rst_b_pulse", pulse_b, 4'h0);
    check("rst_b_event", event_b, 4'h0);
  endtask

  task automatic applyStimulus(input logic [1:0] a_in, input logic [3:0] b_in,
                               input logic [1:0] ca, input logic [3:0] cb);
    async_a = a_in; async_b = b_in; clear_a = ca; clear_b = cb;
  endtask

  task automatic tick();
    @(negedge clk);
    checkOutput();
  endtask

  initial begin
    int pc0, pc1;
    int hold[4];
    logic [3:0] b_val;

    mode_a = {MODE_RISE, MODE_FALL};
    mode_b = {MODE_BOTH, MODE_FALL, MODE_RISE, MODE_NONE};
    applyStimulus(2'b11, 4'hF, 2'b00, 4'h0);
    repeat (3) @(negedge clk);
    checkReset();
    rst_n = 1'b1;
    repeat (4) tick();

    // Clean falling transition on ch0: pulse exactly 5 edges after first sample.
    applyStimulus(2'b10, 4'hF, 2'b00, 4'h0);
    for (int k = 0; k < 7; k++) begin
      tick();
      check("fall_level", level_a[0], (k < 5));
      check("fall_pulse", pulse_a[0], (k == 5));
    end
    check("fall_event", event_a[0], 1'b1);
    repeat (3) tick();
    applyStimulus(2'b10, 4'hF, 2'b01, 4'h0);
    tick();
    applyStimulus(2'b10, 4'hF, 2'b00, 4'h0);
    check("clear_event", event_a[0], 1'b0);

    // Rising back is not selected in fall mode; then a 3-clock glitch is rejected.
    applyStimulus(2'b11, 4'hF, 2'b00, 4'h0);
    repeat (8) tick();
    check("rise_level", level_a[0], 1'b1);
    check("rise_no_event", event_a[0], 1'b0);
    pc0 = 0;
    applyStimulus(2'b10, 4'hF, 2'b00, 4'h0);
    for (int k = 0; k < 11; k++) begin
      if (k == 3) applyStimulus(2'b11, 4'hF, 2'b00, 4'h0);
      tick();
      pc0 += int'(pulse_a[0]);
      check("glitch_level", level_a[0], 1'b1);
    end
    check("glitch_pulses", pc0, 0);
    check("glitch_cnt", 32'(dut_a.g_ch[0].u_ch.cnt_q), 32'd0);

    // Two channels with different modes toggled 0->1->0.
    mode_a = {MODE_NONE, MODE_NONE};
    applyStimulus(2'b00, 4'hF, 2'b00, 4'h0);
    repeat (10) tick();
    check("toggle_prep_level", level_a, 2'b00);
    check("toggle_prep_event", event_a, 2'b00);
    mode_a = {MODE_RISE, MODE_BOTH};
    pc0 = 0; pc1 = 0;
    applyStimulus(2'b11, 4'hF, 2'b00, 4'h0);
    repeat (10) begin tick(); pc0 += int'(pulse_a[0]); pc1 += int'(pulse_a[1]); end
    applyStimulus(2'b00, 4'hF, 2'b00, 4'h0);
    repeat (10) begin tick(); pc0 += int'(pulse_a[0]); pc1 += int'(pulse_a[1]); end
    check("toggle_ch0_pulses", pc0, 2);
    check("toggle_ch1_pulses", pc1, 1);
    check("toggle_events", event_a, 2'b11);

    // Clear coinciding with the set edge loses to the set; a lone clear wins.
    mode_a[1:0] = MODE_FALL;
    applyStimulus(2'b01, 4'hF, 2'b00, 4'h0);
    repeat (10) tick();
    applyStimulus(2'b01, 4'hF, 2'b11, 4'h0);
    tick();
    applyStimulus(2'b01, 4'hF, 2'b00, 4'h0);
    check("pre_clash_event", event_a, 2'b00);
    applyStimulus(2'b00, 4'hF, 2'b00, 4'h0);
    for (int k = 0; k < 7; k++) begin
      tick();
      if (k == 5) begin
        check("clash_pulse", pulse_a[0], 1'b1);
        check("clash_event", event_a[0], 1'b1);
      end
      if (k == 6) check("lone_clear_event", event_a[0], 1'b0);
      applyStimulus(2'b00, 4'hF, ((k == 4) || (k == 5)) ? 2'b01 : 2'b00, 4'h0);
    end

    // Reset mid-filter discards the count; full latency applies after release.
    applyStimulus(2'b01, 4'hF, 2'b00, 4'h0);
    repeat (10) tick();
    check("pre_rst_level", level_a[0], 1'b1);
    applyStimulus(2'b00, 4'hF, 2'b00, 4'h0);
    repeat (4) tick();
    check("pre_rst_cnt", 32'(dut_a.g_ch[0].u_ch.cnt_q), 32'd2);
    rst_n = 1'b0;
    #1;
    checkReset();
    repeat (2) @(negedge clk);
    checkReset();
    rst_n = 1'b1;
    check("release_level", level_a[0], 1'b1);
    pc0 = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      pc0 += int'(pulse_a[0]);
      check("post_rst_level", level_a[0], (k < 5));
      check("post_rst_pulse", pulse_a[0], (k == 5));
    end
    check("post_rst_pulses", pc0, 1);

    // Randomised traffic on the single-cycle-filter instance, all modes.
    b_val = 4'hF;
    for (int c = 0; c < 4; c++) hold[c] = 3;
    for (int cyc = 0; cyc < 300; cyc++) begin
      for (int c = 0; c < 4; c++) begin
        if (hold[c] == 0) begin
          b_val[c] = 1'($urandom_range(0, 1));
          hold[c]  = int'($urandom_range(3, 6));
        end else begin
          hold[c]--;
        end
      end
      if (cyc % 25 == 0) mode_b = 8'($urandom);
      applyStimulus(async_a, b_val, 2'b00,
                    ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'h0);
      tick();
    end
    applyStimulus(async_a, b_val, 2'b00, 4'h0);
    repeat (2) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
